// File: rtl/fir_bank_mac_seq.sv
// fir_bank_mac_seq: tap-phase sequencer, coefficient store and 3-stage
// signed MAC shared by one polyphase FIR bank. The bank feeds operands
// back on dsp_a/dsp_b and latches dsp_p at tap_addr == LATCH_ADDR.
module fir_bank_mac_seq #(
    parameter int M            = 20,
    parameter int BANK_LEN     = 6,
    parameter int INPUT_WIDTH  = 12,
    parameter int TAP_WIDTH    = 16,
    parameter int OUTPUT_WIDTH = 35,
    parameter int LATCH_ADDR   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [$clog2(M)-1:0]           tap_addr,
    output logic signed [TAP_WIDTH-1:0]    tap,
    output logic                           dsp_acc,
    input  logic signed [TAP_WIDTH-1:0]    dsp_a,
    input  logic signed [INPUT_WIDTH-1:0]  dsp_b,
    output logic signed [OUTPUT_WIDTH-1:0] dsp_p,
    input  logic                           coef_we,
    input  logic [$clog2(BANK_LEN)-1:0]    coef_waddr,
    input  logic signed [TAP_WIDTH-1:0]    coef_wdata,
    output logic                           frame_start,
    output logic                           dout_valid
);

    localparam int AW = $clog2(M);
    localparam int PW = TAP_WIDTH + INPUT_WIDTH;

    // phase counter
    logic [AW-1:0] tap_addr_q, tap_addr_d;
    logic [31:0]   addr32;
    logic [31:0]   waddr32;

    // coefficient store
    logic signed [TAP_WIDTH-1:0] coef_q [BANK_LEN];
    logic signed [TAP_WIDTH-1:0] coef_d [BANK_LEN];

    // MAC pipeline: stage 1 operands, stage 2 product, stage 3 accumulator
    logic signed [TAP_WIDTH-1:0]    a_q, a_d;
    logic signed [INPUT_WIDTH-1:0]  b_q, b_d;
    logic                           first1_q, first1_d;
    logic signed [PW-1:0]           m_q, m_d;
    logic                           first2_q, first2_d;
    logic signed [OUTPUT_WIDTH-1:0] dsp_p_q, dsp_p_d;
    logic signed [OUTPUT_WIDTH-1:0] m_ext;

    // dout_valid is held off until one full frame has run since reset
    logic armed_q, armed_d;
    logic dout_valid_q, dout_valid_d;

    assign addr32  = 32'(tap_addr_q);
    assign waddr32 = 32'(coef_waddr);

    // Free-running phase counter, tap lookup and frame control decode
    always_comb begin
        tap_addr_d  = (addr32 == M - 1) ? '0 : tap_addr_q + AW'(1);
        tap         = '0;
        for (int i = 0; i < BANK_LEN; i++) begin
            if (addr32 == i) tap = coef_q[i];
        end
        frame_start = (tap_addr_q == '0);
        dsp_acc     = (tap_addr_q != '0);
    end

    // Coefficient writes; out-of-range indices match no register and drop
    always_comb begin
        for (int i = 0; i < BANK_LEN; i++) begin
            coef_d[i] = coef_q[i];
            if (coef_we && (waddr32 == i)) coef_d[i] = coef_wdata;
        end
    end

    // MAC datapath: full-width signed product, sign-extended, wrapping add
    always_comb begin
        a_d      = dsp_a;
        b_d      = dsp_b;
        first1_d = (tap_addr_q == '0);
        m_d      = $signed({{INPUT_WIDTH{a_q[TAP_WIDTH-1]}}, a_q}) *
                   $signed({{TAP_WIDTH{b_q[INPUT_WIDTH-1]}}, b_q});
        first2_d = first1_q;
        m_ext    = {{(OUTPUT_WIDTH-PW){m_q[PW-1]}}, m_q};
        dsp_p_d  = first2_q ? m_ext : dsp_p_q + m_ext;
    end

    // Completion pulse: one cycle after the latch phase, once armed
    always_comb begin
        armed_d      = armed_q | (addr32 == M - 1);
        dout_valid_d = armed_q & (addr32 == LATCH_ADDR);
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_addr_q   <= '0;
            for (int i = 0; i < BANK_LEN; i++) coef_q[i] <= '0;
            a_q          <= '0;
            b_q          <= '0;
            first1_q     <= 1'b0;
            m_q          <= '0;
            first2_q     <= 1'b0;
            dsp_p_q      <= '0;
            armed_q      <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            tap_addr_q   <= tap_addr_d;
            for (int i = 0; i < BANK_LEN; i++) coef_q[i] <= coef_d[i];
            a_q          <= a_d;
            b_q          <= b_d;
            first1_q     <= first1_d;
            m_q          <= m_d;
            first2_q     <= first2_d;
            dsp_p_q      <= dsp_p_d;
            armed_q      <= armed_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign tap_addr   = tap_addr_q;
    assign dsp_p      = dsp_p_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fir_bank_mac_seq.sv
// Directed bench for fir_bank_mac_seq with a small polyphase bank model
// that returns coefficient/sample operands per tap phase.
module tb_fir_bank_mac_seq;

    localparam int M = 20;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [4:0]          tap_addr;
    logic signed [15:0]  tap;
    logic                dsp_acc;
    logic signed [15:0]  dsp_a = '0;
    logic signed [11:0]  dsp_b = '0;
    logic signed [34:0]  dsp_p;
    logic                coef_we = 1'b0;
    logic [2:0]          coef_waddr = '0;
    logic signed [15:0]  coef_wdata = '0;
    logic                frame_start;
    logic                dout_valid;

    int vecs = 0;
    int errs = 0;

    logic signed [11:0] din = '0;
    logic signed [11:0] hist [6] = '{default: '0};

    always #5 clk = ~clk;

    fir_bank_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .tap_addr(tap_addr), .tap(tap),
        .dsp_acc(dsp_acc), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_p(dsp_p),
        .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata),
        .frame_start(frame_start), .dout_valid(dout_valid)
    );

    // Bank model: new sample enters at phase 0, tap k pairs coef[k] with x[n-k]
    always @(negedge clk) begin
        if (rst_n && tap_addr == 0) begin
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = din;
        end
        if (tap_addr < 6) begin
            dsp_a = tap;
            dsp_b = hist[tap_addr];
        end else begin
            dsp_a = '0;
            dsp_b = '0;
        end
    end

    task automatic wait_addr(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tap_addr != v && n < 2*M);
        if (tap_addr != v) begin
            vecs++; errs++;
            $display("FAIL wait_addr: tap_addr=%0d, wanted %0d", tap_addr, v);
        end
    endtask

    task automatic write_coef(input int idx, input logic signed [15:0] val);
        @(negedge clk);
        coef_we = 1'b1; coef_waddr = 3'(idx); coef_wdata = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (tap_addr !== 5'd0) begin errs++; $display("FAIL reset_addr: got %0d want 0", tap_addr); end
        vecs++; if (dsp_p !== 35'sd0) begin errs++; $display("FAIL reset_dsp_p: got %0d want 0", dsp_p); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        vecs++; if (frame_start !== 1'b1) begin errs++; $display("FAIL reset_frame_start: got %b want 1", frame_start); end
        vecs++; if (dsp_acc !== 1'b0) begin errs++; $display("FAIL reset_dsp_acc: got %b want 0", dsp_acc); end
        vecs++; if (tap !== 16'sd0) begin errs++; $display("FAIL reset_tap: got %0d want 0", tap); end
    endtask

    // Release at a negedge; sample n after release shows phase n mod M
    task automatic test_counter();
        rst_n = 1'b1;
        for (int n = 0; n <= 60; n++) begin
            if (n > 0) @(negedge clk);
            vecs++; if (tap_addr !== 5'(n % M)) begin errs++; $display("FAIL cnt_addr n=%0d: got %0d want %0d", n, tap_addr, n % M); end
            vecs++; if (frame_start !== (n % M == 0)) begin errs++; $display("FAIL cnt_frame_start n=%0d: got %b", n, frame_start); end
            vecs++; if (dsp_acc !== (n % M != 0)) begin errs++; $display("FAIL cnt_dsp_acc n=%0d: got %b", n, dsp_acc); end
            vecs++; if (dout_valid !== (n == 29 || n == 49)) begin errs++; $display("FAIL cnt_dout_valid n=%0d: got %b want %b", n, dout_valid, (n == 29 || n == 49)); end
        end
    endtask

    task automatic test_const_sum();
        for (int i = 0; i < 6; i++) write_coef(i, 16'sd1);
        din = 12'sd3;
        repeat (7) wait_addr(0);
        for (int f = 0; f < 2; f++) begin
            wait_addr(8);
            vecs++; if (dsp_p !== 35'sd18) begin errs++; $display("FAIL const_sum f=%0d: got %0d want 18", f, dsp_p); end
            @(negedge clk);
            vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL const_dout_valid f=%0d: got %b want 1", f, dout_valid); end
        end
    endtask

    task automatic test_impulse();
        logic signed [34:0] exp_v [7];
        exp_v = '{35'sd1, 35'sd2, 35'sd3, 35'sd4, 35'sd5, 35'sd6, 35'sd0};
        for (int i = 0; i < 6; i++) write_coef(i, 16'(i + 1));
        din = 12'sd0;
        repeat (7) wait_addr(0);
        wait_addr(19);
        din = 12'sd1;
        wait_addr(0);
        wait_addr(1);
        din = 12'sd0;
        for (int i = 0; i < 7; i++) begin
            wait_addr(8);
            vecs++; if (dsp_p !== exp_v[i]) begin errs++; $display("FAIL impulse out%0d: got %0d want %0d", i, dsp_p, exp_v[i]); end
            @(negedge clk);
            vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL impulse_valid out%0d: got %b want 1", i, dout_valid); end
        end
    endtask

    task automatic test_coef_write();
        write_coef(6, 16'sd99);
        wait_addr(0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            vecs++; if (tap !== 16'(k + 1)) begin errs++; $display("FAIL coef_oob tap%0d: got %0d want %0d", k, tap, k + 1); end
        end
        @(negedge clk);
        vecs++; if (tap !== 16'sd0) begin errs++; $display("FAIL coef_tap_beyond: got %0d want 0", tap); end
        wait_addr(2);
        coef_we = 1'b1; coef_waddr = 3'd2; coef_wdata = 16'sd7;
        vecs++; if (tap !== 16'sd3) begin errs++; $display("FAIL coef_same_cycle: got %0d want 3", tap); end
        @(negedge clk);
        coef_we = 1'b0;
        vecs++; if (tap !== 16'sd4) begin errs++; $display("FAIL coef_next_tap: got %0d want 4", tap); end
        wait_addr(2);
        vecs++; if (tap !== 16'sd7) begin errs++; $display("FAIL coef_new_frame: got %0d want 7", tap); end
    endtask

    task automatic test_signed();
        logic signed [34:0] e;
        for (int i = 0; i < 6; i++) write_coef(i, -16'sd32768);
        din = -12'sd2048;
        repeat (7) wait_addr(0);
        wait_addr(8);
        e = 35'sd402653184;
        vecs++; if (dsp_p !== e) begin errs++; $display("FAIL signed_max: got %0d want %0d", dsp_p, e); end
        @(negedge clk);
        vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL signed_max_valid: got %b want 1", dout_valid); end
        for (int i = 0; i < 6; i++) write_coef(i, -16'sd1);
        din = 12'sd2047;
        repeat (7) wait_addr(0);
        wait_addr(8);
        e = -35'sd12282;
        vecs++; if (dsp_p !== e) begin errs++; $display("FAIL signed_neg: got %0d want %0d", dsp_p, e); end
    endtask

    task automatic test_mid_reset();
        wait_addr(4);
        rst_n = 1'b0;
        #1;
        vecs++; if (tap_addr !== 5'd0) begin errs++; $display("FAIL midrst_addr: got %0d want 0", tap_addr); end
        vecs++; if (dsp_p !== 35'sd0) begin errs++; $display("FAIL midrst_dsp_p: got %0d want 0", dsp_p); end
        vecs++; if (tap !== 16'sd0) begin errs++; $display("FAIL midrst_tap: got %0d want 0", tap); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL midrst_dout_valid: got %b want 0", dout_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) @(negedge clk);
            vecs++; if (tap_addr !== 5'(n % M)) begin errs++; $display("FAIL midrst_cnt n=%0d: got %0d want %0d", n, tap_addr, n % M); end
            vecs++; if (dout_valid !== (n == 29)) begin errs++; $display("FAIL midrst_valid n=%0d: got %b want %b", n, dout_valid, (n == 29)); end
            if (n < 6) begin
                vecs++; if (tap !== 16'sd0) begin errs++; $display("FAIL midrst_coef_clr n=%0d: got %0d want 0", n, tap); end
            end
            if (n == 8) begin
                vecs++; if (dsp_p !== 35'sd0) begin errs++; $display("FAIL midrst_sum: got %0d want 0", dsp_p); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_const_sum();
        test_impulse();
        test_coef_write();
        test_signed();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
